// File: rtl/unpacker_pkg.sv
// Shared constants, arbiter state type and vbc clamping helper for the
// unpacker input arbiter.
package unpacker_pkg;

    localparam int DATA_W  = 1280;
    localparam int MAX_VBC = 160;
    localparam int VBC_W   = 8;

    typedef enum logic [0:0] {
        ARB = 1'b0,
        PKT = 1'b1
    } arb_state_e;

    // Limit a beat's valid byte count to the largest legal value.
    function automatic logic [VBC_W-1:0] clamp_vbc(input logic [VBC_W-1:0] vbc,
                                                   input logic [VBC_W-1:0] max_vbc);
        return (vbc > max_vbc) ? max_vbc : vbc;
    endfunction

endpackage

// File: rtl/unpacker_arb_rr_arbiter.sv
// Combinational round-robin picker: the first requester at or above ptr,
// wrapping around, receives a one-hot grant.
module rr_arbiter #(
    parameter int N_P = 4
) (
    input  logic [N_P-1:0]         req,
    input  logic [$clog2(N_P)-1:0] ptr,
    output logic [N_P-1:0]         gnt
);

    localparam int PW = $clog2(N_P);

    logic          found;
    logic [PW-1:0] idx;

    // Scan from ptr upward with wrap and keep the first hit.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_P; k++) begin
            idx = PW'((int'(ptr) + k) % N_P);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/unpacker_arb.sv
// N-source packet arbiter feeding a single unpacker. The grant is held from
// sop to eop, the output stage is a single back-pressured register, and
// protocol violations are cleaned up and counted.
module unpacker_arb
    import unpacker_pkg::*;
#(
    parameter int N_P       = 4,
    parameter int DATA_W    = 1280,
    parameter int MAX_VBC   = 160,
    parameter int TIMEOUT_P = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_P-1:0]          in_val,
    input  logic [N_P-1:0]          in_sop,
    input  logic [N_P-1:0]          in_eop,
    input  logic [N_P*VBC_W-1:0]    in_vbc,
    input  logic [N_P*DATA_W-1:0]   in_data,
    output logic [N_P-1:0]          in_ready,
    input  logic                    u_ready,
    output logic                    o_val,
    output logic                    o_sop,
    output logic                    o_eop,
    output logic [VBC_W-1:0]        o_vbc,
    output logic [DATA_W-1:0]       o_data,
    output logic [N_P-1:0]          grant,
    output logic                    err,
    output logic [15:0]             err_cnt
);

    localparam int PTR_W = $clog2(N_P);
    localparam int TMO_W = $clog2(TIMEOUT_P + 1);
    localparam logic [VBC_W-1:0] MAX_VBC_L = VBC_W'(MAX_VBC);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_P - 1);

    arb_state_e          state_q, state_d;
    logic [N_P-1:0]      grant_q, grant_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                first_q, first_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                oval_q, oval_d;
    logic                osop_q, osop_d;
    logic                oeop_q, oeop_d;
    logic [VBC_W-1:0]    ovbc_q, ovbc_d;
    logic [DATA_W-1:0]   odata_q, odata_d;
    logic                err_q, err_d;
    logic [15:0]         err_cnt_q, err_cnt_d;

    logic [N_P-1:0]      req, stray, arb_gnt;
    logic                load_en;
    logic [PTR_W-1:0]    g_idx, ptr_next;
    logic                g_val, g_sop, g_eop;
    logic [VBC_W-1:0]    g_vbc;
    logic [DATA_W-1:0]   g_data;

    assign req     = in_val & in_sop;
    assign stray   = in_val & ~in_sop;
    assign load_en = !oval_q || u_ready;

    rr_arbiter #(.N_P(N_P)) u_rr (
        .req (req),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt)
    );

    // Decode the owner index and select the owner's beat fields.
    always_comb begin
        g_idx = '0;
        for (int k = 0; k < N_P; k++) begin
            if ((grant_q >> k) & N_P'(1)) g_idx = PTR_W'(k);
        end
        g_val    = |(in_val & grant_q);
        g_sop    = |(in_sop & grant_q);
        g_eop    = |(in_eop & grant_q);
        g_vbc    = VBC_W'(in_vbc >> (int'(g_idx) * VBC_W));
        g_data   = DATA_W'(in_data >> (int'(g_idx) * DATA_W));
        ptr_next = (g_idx == PTR_W'(N_P - 1)) ? '0 : g_idx + PTR_W'(1);
    end

    // Arbitration / packet FSM, output stage loading and error detection.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        first_d  = first_q;
        tmo_d    = tmo_q;
        oval_d   = oval_q;
        osop_d   = osop_q;
        oeop_d   = oeop_q;
        ovbc_d   = ovbc_q;
        odata_d  = odata_q;
        err_d    = 1'b0;
        in_ready = '0;

        // A drained or empty output register goes invalid unless refilled below.
        if (load_en) oval_d = 1'b0;

        case (state_q)
            ARB: begin
                // Beats without sop have no owner: swallow them and flag once per cycle.
                in_ready = stray;
                if (|stray) err_d = 1'b1;
                if (|req) begin
                    grant_d = arb_gnt;
                    state_d = PKT;
                    first_d = 1'b1;
                    tmo_d   = '0;
                end
            end
            PKT: begin
                in_ready = grant_q & {N_P{load_en}};
                if (g_val && load_en) begin
                    tmo_d = '0;
                    if ((g_sop && !first_q) || (g_vbc > MAX_VBC_L) || (g_vbc == '0))
                        err_d = 1'b1;
                    // Empty beats are dropped; first_q stays set so the next real beat carries sop.
                    if (g_vbc != '0) begin
                        oval_d  = 1'b1;
                        osop_d  = first_q;
                        oeop_d  = g_eop;
                        ovbc_d  = clamp_vbc(g_vbc, MAX_VBC_L);
                        odata_d = g_data;
                        first_d = 1'b0;
                    end
                    if (g_eop) begin
                        grant_d  = '0;
                        rr_ptr_d = ptr_next;
                        state_d  = ARB;
                    end
                end else if (!g_val && load_en) begin
                    // Idle owner: count only while the output side is not stalling us.
                    if (tmo_q == TMO_LAST) begin
                        err_d    = 1'b1;
                        grant_d  = '0;
                        rr_ptr_d = ptr_next;
                        state_d  = ARB;
                        tmo_d    = '0;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            default: state_d = ARB;
        endcase

        err_cnt_d = (err_d && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARB;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            first_q   <= 1'b0;
            tmo_q     <= '0;
            oval_q    <= 1'b0;
            osop_q    <= 1'b0;
            oeop_q    <= 1'b0;
            ovbc_q    <= '0;
            odata_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            first_q   <= first_d;
            tmo_q     <= tmo_d;
            oval_q    <= oval_d;
            osop_q    <= osop_d;
            oeop_q    <= oeop_d;
            ovbc_q    <= ovbc_d;
            odata_q   <= odata_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_val   = oval_q;
    assign o_sop   = osop_q;
    assign o_eop   = oeop_q;
    assign o_vbc   = ovbc_q;
    assign o_data  = odata_q;
    assign grant   = grant_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule
